// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: selects ALU operands, forwards write-back results and
// presents them through a two-entry valid/ready buffer with a registered in_ready.
module alu_operand_stage #(
  parameter int OP_W = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_opcode,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_left_pc,
  input  logic            in_right_imm,
  input  logic [4:0]      in_rd_idx,
  input  logic            in_rd_we,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd_idx,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_opcode,
  output logic [XLEN-1:0] out_left,
  output logic [XLEN-1:0] out_right,
  output logic [4:0]      out_rd_idx,
  output logic            out_rd_we
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  // leftReg/rightReg mark operands that came from the register file and may
  // still be overwritten by a later write-back while the entry waits.
  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [XLEN-1:0] left;
    logic [XLEN-1:0] right;
    logic [4:0]      rdIdx;
    logic            rdWe;
    logic [4:0]      rs1Idx;
    logic [4:0]      rs2Idx;
    logic            leftReg;
    logic            rightReg;
  } entry_t;

  logic [1:0] state_q, state_d;
  logic       inReady_q, inReady_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;

  entry_t     mainFwd;
  entry_t     skidFwd;
  entry_t     newEntry;
  logic       accept;
  logic       pop;

  function automatic logic wbHits(input logic we, input logic [4:0] wbIdx,
                                  input logic [4:0] srcIdx);
    return we && (wbIdx != 5'd0) && (wbIdx == srcIdx);
  endfunction

  function automatic entry_t fwdEntry(input entry_t e, input logic we,
                                      input logic [4:0] wbIdx,
                                      input logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (e.leftReg && wbHits(we, wbIdx, e.rs1Idx)) begin
      r.left = data;
    end
    if (e.rightReg && wbHits(we, wbIdx, e.rs2Idx)) begin
      r.right = data;
    end
    return r;
  endfunction

  assign accept = in_valid && inReady_q;
  assign pop    = out_valid && out_ready;

  always_comb begin
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    rs1v = wbHits(wb_we, wb_rd_idx, in_rs1_idx) ? wb_data : in_rs1_val;
    rs2v = wbHits(wb_we, wb_rd_idx, in_rs2_idx) ? wb_data : in_rs2_val;
    newEntry.opcode   = in_opcode;
    newEntry.left     = in_left_pc ? in_pc : rs1v;
    newEntry.right    = in_right_imm ? in_imm : rs2v;
    newEntry.rdIdx    = in_rd_idx;
    newEntry.rdWe     = in_rd_we;
    newEntry.rs1Idx   = in_rs1_idx;
    newEntry.rs2Idx   = in_rs2_idx;
    newEntry.leftReg  = !in_left_pc;
    newEntry.rightReg = !in_right_imm;
  end

  assign mainFwd = fwdEntry(main_q, wb_we, wb_rd_idx, wb_data);
  assign skidFwd = fwdEntry(skid_q, wb_we, wb_rd_idx, wb_data);

  // Held entries pick up forwards by default; the case only handles movement.
  always_comb begin
    state_d = state_q;
    main_d  = mainFwd;
    skid_d  = skidFwd;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = newEntry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = newEntry;
        end else if (accept) begin
          skid_d  = newEntry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_d  = skidFwd;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    inReady_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      inReady_q <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      inReady_q <= inReady_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
    end
  end

  assign in_ready   = inReady_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_opcode = main_q.opcode;
  assign out_left   = main_q.left;
  assign out_right  = main_q.right;
  assign out_rd_idx = main_q.rdIdx;
  assign out_rd_we  = main_q.rdWe;

endmodule
